// File: rtl/controller_responder.sv
// ---------------------------------------------------------------------------
// controller_responder
//
// Purpose: the responding end of a latch/pulse/data serial game-pad link.
// The block emulates a physical pad. While latch is high it loads a parallel
// button vector. After latch falls it shifts one bit out per pulse rising
// edge on an active-low data line. It reports completed frames and frames
// that were abandoned because no pulse arrived in time.
//
// Optional feature macro: CTRL_RESP_TURBO_EN
//   When defined, the I_TURBO_MASK port is added. Masked buttons are forced
//   to "released" on alternate groups of TURBO_FRAMES completed frames.
//
// Ports:
//   I_CLK               block clock
//   I_RESET             asynchronous, active-high reset
//   I_CONTROLLER_LATCH  latch from the initiator (asynchronous to I_CLK)
//   I_CONTROLLER_PULSE  shift clock from the initiator (asynchronous)
//   I_BUTTONS           button state, active-high, bit 0 shifted first
//   I_TURBO_MASK        per-button turbo enable (CTRL_RESP_TURBO_EN only)
//   O_CONTROLLER_DATA   serial data, active-low (0 = pressed)
//   O_FRAME_DONE        one-cycle pulse when a frame completes
//   O_FRAME_COUNT       completed frame count, wraps modulo 2^16
//   O_TIMEOUT           one-cycle pulse when an open frame is abandoned
//   O_BUSY              high while a frame is latched, shifting or done
// ---------------------------------------------------------------------------
module controller_responder #(
  parameter int       NUM_BITS       = 16,
  parameter logic     FILL_LEVEL     = 1'b0,
  parameter int       TIMEOUT_CYCLES = 4096,
  parameter int       TURBO_FRAMES   = 4
) (
  input  logic                I_CLK,
  input  logic                I_RESET,
  input  logic                I_CONTROLLER_LATCH,
  input  logic                I_CONTROLLER_PULSE,
  input  logic [NUM_BITS-1:0] I_BUTTONS,
`ifdef CTRL_RESP_TURBO_EN
  input  logic [NUM_BITS-1:0] I_TURBO_MASK,
`endif
  output logic                O_CONTROLLER_DATA,
  output logic                O_FRAME_DONE,
  output logic [15:0]         O_FRAME_COUNT,
  output logic                O_TIMEOUT,
  output logic                O_BUSY
);

  localparam int IDX_W  = $clog2(NUM_BITS);
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BITS - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  // Elaboration-time guard on parameter legality.
  if (NUM_BITS < 2 || NUM_BITS > 32 || TIMEOUT_CYCLES < 2 || TURBO_FRAMES < 1) begin : g_bad_param
    $error("controller_responder: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCHED = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  logic [NUM_BITS-1:0] r_shreg;
  logic [IDX_W-1:0]    r_idx;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_data;
  logic                r_done;
  logic                r_timeout;
  logic                r_busy;
  logic [15:0]         r_count;

  // Two-flop synchronizers plus one history flop per input pin.
  logic r_latch_s1, r_latch_s2, r_latch_h;
  logic r_pulse_s1, r_pulse_s2, r_pulse_h;

  logic                w_latch_rise;
  logic                w_latch_fall;
  logic                w_pulse_rise;
  logic [IDX_W-1:0]    w_next_idx;
  logic [NUM_BITS-1:0] w_buttons_eff;

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_latch_s1 <= 1'b0;
      r_latch_s2 <= 1'b0;
      r_latch_h  <= 1'b0;
      r_pulse_s1 <= 1'b0;
      r_pulse_s2 <= 1'b0;
      r_pulse_h  <= 1'b0;
    end else begin
      r_latch_s1 <= I_CONTROLLER_LATCH;
      r_latch_s2 <= r_latch_s1;
      r_latch_h  <= r_latch_s2;
      r_pulse_s1 <= I_CONTROLLER_PULSE;
      r_pulse_s2 <= r_pulse_s1;
      r_pulse_h  <= r_pulse_s2;
    end
  end

  assign w_latch_rise = r_latch_s2 & ~r_latch_h;
  assign w_latch_fall = ~r_latch_s2 & r_latch_h;
  assign w_pulse_rise = r_pulse_s2 & ~r_pulse_h;
  assign w_next_idx   = r_idx + 1'b1;

`ifdef CTRL_RESP_TURBO_EN
  localparam int TURBO_W = $clog2(TURBO_FRAMES + 1);
  localparam logic [TURBO_W-1:0] TURBO_LAST = TURBO_W'(TURBO_FRAMES - 1);

  logic               r_turbo_phase;
  logic [TURBO_W-1:0] r_turbo_cnt;

  // The registered done pulse marks each completed frame; the phase only
  // matters at the next parallel load, so the one-cycle lag is harmless.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_turbo_phase <= 1'b0;
      r_turbo_cnt   <= '0;
    end else if (r_done) begin
      if (r_turbo_cnt == TURBO_LAST) begin
        r_turbo_cnt   <= '0;
        r_turbo_phase <= ~r_turbo_phase;
      end else begin
        r_turbo_cnt <= r_turbo_cnt + 1'b1;
      end
    end
  end

  assign w_buttons_eff = I_BUTTONS & ~(I_TURBO_MASK & {NUM_BITS{r_turbo_phase}});
`else
  assign w_buttons_eff = I_BUTTONS;
`endif

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_idx     <= '0;
      r_tcnt    <= '0;
      r_data    <= 1'b1;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
      r_count   <= 16'h0000;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      // A new latch always wins, whatever the frame was doing.
      if (w_latch_rise) begin
        r_state <= ST_LATCHED;
        r_shreg <= w_buttons_eff;
        r_data  <= ~w_buttons_eff[0];
        r_idx   <= '0;
        r_tcnt  <= '0;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_data <= 1'b1;
            r_busy <= 1'b0;
          end
          ST_LATCHED: begin
            if (w_latch_fall) begin
              // Keep the last load; bit 0 is already on the line.
              r_state <= ST_SHIFT;
              r_idx   <= '0;
              r_tcnt  <= '0;
              r_data  <= ~r_shreg[0];
            end else begin
              r_shreg <= w_buttons_eff;
              r_data  <= ~w_buttons_eff[0];
            end
          end
          ST_SHIFT: begin
            if (w_pulse_rise) begin
              r_tcnt <= '0;
              if (r_idx == LAST_IDX) begin
                r_state <= ST_DONE;
                r_data  <= FILL_LEVEL;
                r_done  <= 1'b1;
                r_count <= r_count + 16'd1;
              end else begin
                r_idx  <= w_next_idx;
                r_data <= ~r_shreg[w_next_idx];
              end
            end else if (r_tcnt == TCNT_LAST) begin
              r_state   <= ST_IDLE;
              r_data    <= 1'b1;
              r_timeout <= 1'b1;
              r_busy    <= 1'b0;
              r_tcnt    <= '0;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          ST_DONE: begin
            if (w_pulse_rise) begin
              r_tcnt <= '0;
              r_data <= FILL_LEVEL;
            end else if (r_tcnt == TCNT_LAST) begin
              r_state   <= ST_IDLE;
              r_data    <= 1'b1;
              r_timeout <= 1'b1;
              r_busy    <= 1'b0;
              r_tcnt    <= '0;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_data  <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign O_CONTROLLER_DATA = r_data;
  assign O_FRAME_DONE      = r_done;
  assign O_FRAME_COUNT     = r_count;
  assign O_TIMEOUT         = r_timeout;
  assign O_BUSY            = r_busy;

endmodule

// File: tb/tb_controller_responder.sv
// ---------------------------------------------------------------------------
// tb_controller_responder
//
// Self-checking bench for controller_responder (NUM_BITS=16, FILL_LEVEL=0).
// Expected serial data comes from a frame-level reference: after k pulses the
// line shows ~buttons[k] for k < 16 and the fill level afterwards. A frame is
// complete once at least 16 pulses have been given.
// ---------------------------------------------------------------------------
module tb_controller_responder;

  localparam int   NB   = 16;
  localparam logic FILL = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        latch;
  logic        pulse;
  logic [15:0] buttons;
  logic        data;
  logic        done;
  logic [15:0] fcount;
  logic        tmo;
  logic        busy;
`ifdef CTRL_RESP_TURBO_EN
  logic [15:0] tmask;
`endif

  controller_responder #(
    .NUM_BITS       (NB),
    .FILL_LEVEL     (FILL),
    .TIMEOUT_CYCLES (4096),
    .TURBO_FRAMES   (4)
  ) dut (
    .I_CLK              (clk),
    .I_RESET            (rst),
    .I_CONTROLLER_LATCH (latch),
    .I_CONTROLLER_PULSE (pulse),
    .I_BUTTONS          (buttons),
`ifdef CTRL_RESP_TURBO_EN
    .I_TURBO_MASK       (tmask),
`endif
    .O_CONTROLLER_DATA  (data),
    .O_FRAME_DONE       (done),
    .O_FRAME_COUNT      (fcount),
    .O_TIMEOUT          (tmo),
    .O_BUSY             (busy)
  );

  always #5 clk = ~clk;

  int          n_checks  = 0;
  int          n_pass    = 0;
  int          done_seen = 0;
  int          tmo_seen  = 0;
  logic [15:0] exp_count = 16'h0000;

  // Pulse monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (done) done_seen <= done_seen + 1;
    if (tmo)  tmo_seen  <= tmo_seen + 1;
  end

  typedef struct {
    logic [15:0] buttons;
    int          npulses;
    logic        exp_data;
    logic        exp_done;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: line level after k pulses of a frame loaded with b.
  function automatic logic ref_bit(input logic [15:0] b, input int k);
    if (k < NB) return ~b[k];
    return FILL;
  endfunction

  task automatic latch_frame(input logic [15:0] b);
    buttons = b;
    latch   = 1'b1;
    repeat (10) @(negedge clk);
    latch   = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic one_pulse();
    pulse = 1'b1;
    repeat (8) @(negedge clk);
    pulse = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_count = 16'h0000;
  endtask

  // Full frame checked bit by bit against the reference.
  task automatic model_frame(input logic [15:0] b, input int np, input string tag);
    int   d0;
    logic exp_done;
    d0 = done_seen;
    latch_frame(b);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_bit0"}, data, ref_bit(b, 0));
    for (int k = 1; k <= np; k++) begin
      one_pulse();
      chk($sformatf("%s_p%0d", tag, k), data, ref_bit(b, k));
    end
    exp_done = (np >= NB);
    if (exp_done) exp_count = exp_count + 16'd1;
    chk({tag, "_done"}, done_seen - d0, exp_done ? 1 : 0);
    chk({tag, "_count"}, fcount, exp_count);
    $display("frame %s buttons=0x%04h pulses=%0d count=0x%04h", tag, b, np, fcount);
  endtask

  initial begin
    int   d0;
    int   t0;
    logic [15:0] b;
    int   np;

    rst = 1'b1; latch = 1'b0; pulse = 1'b0; buttons = 16'h0000;
`ifdef CTRL_RESP_TURBO_EN
    tmask = 16'h0000;
`endif
    tbl[0] = '{16'h0005,  0, 1'b0, 1'b0};
    tbl[1] = '{16'h0005,  1, 1'b1, 1'b0};
    tbl[2] = '{16'h0005,  2, 1'b0, 1'b0};
    tbl[3] = '{16'h0005,  3, 1'b1, 1'b0};
    tbl[4] = '{16'h8000, 15, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 16, 1'b0, 1'b1};
    tbl[6] = '{16'h7FFF, 15, 1'b1, 1'b0};
    tbl[7] = '{16'h7FFF, 16, 1'b0, 1'b1};
    tbl[8] = '{16'h0000,  0, 1'b1, 1'b0};
    tbl[9] = '{16'hFFFF, 18, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data", data, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fcount, 16'h0000);
    chk("rst_done", done, 1'b0);
    chk("rst_tmo", tmo, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      d0 = done_seen;
      latch_frame(tbl[i].buttons);
      for (int k = 0; k < tbl[i].npulses; k++) one_pulse();
      if (tbl[i].exp_done) exp_count = exp_count + 16'd1;
      chk($sformatf("tbl%0d_data", i), data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_done", i), done_seen - d0, tbl[i].exp_done ? 1 : 0);
      chk($sformatf("tbl%0d_count", i), fcount, exp_count);
      $display("vector %0d buttons=0x%04h pulses=%0d data=%0b", i, tbl[i].buttons, tbl[i].npulses, data);
    end

    // Plain 16-bit read of 0x0005
    model_frame(16'h0005, 16, "snes5");
    chk("snes5_busy_done", busy, 1'b1);

    // Buttons change while latch is held high
    buttons = 16'h0000;
    latch   = 1'b1;
    repeat (6) @(negedge clk);
    chk("transp_before", data, 1'b1);
    buttons = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("transp_after", data, 1'b0);
    latch = 1'b0;
    repeat (6) @(negedge clk);
    one_pulse();
    chk("transp_bit1", data, 1'b0);
    $display("transparency sequence data=%0b", data);

    // Latch and pulse rising together mid-shift: new frame from bit 0
    d0 = done_seen;
    latch_frame(16'h0008);
    for (int k = 0; k < 3; k++) one_pulse();
    chk("simul_pre", data, 1'b0);
    latch = 1'b1;
    pulse = 1'b1;
    repeat (10) @(negedge clk);
    latch = 1'b0;
    repeat (6) @(negedge clk);
    chk("simul_bit0", data, 1'b1);
    pulse = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 1; k <= 15; k++) one_pulse();
    chk("simul_nodone", done_seen - d0, 0);
    chk("simul_bit15", data, 1'b1);
    one_pulse();
    exp_count = exp_count + 16'd1;
    chk("simul_done", done_seen - d0, 1);
    chk("simul_fill", data, FILL);
    chk("simul_count", fcount, exp_count);
    $display("simultaneous edge sequence count=0x%04h", fcount);

    // Timeout after 5 pulses
    latch_frame(16'h1234);
    for (int k = 0; k < 5; k++) one_pulse();
    t0 = tmo_seen;
    repeat (4000) @(negedge clk);
    chk("tmo_early", tmo_seen - t0, 0);
    chk("tmo_busy_pre", busy, 1'b1);
    repeat (300) @(negedge clk);
    chk("tmo_once", tmo_seen - t0, 1);
    chk("tmo_data", data, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_count", fcount, exp_count);
    $display("timeout sequence pulses=%0d", tmo_seen - t0);

    // Randomized frames against the reference
    for (int i = 0; i < 20; i++) begin
      b  = 16'($urandom);
      np = int'($urandom_range(0, 18));
      model_frame(b, np, $sformatf("rnd%0d", i));
    end

    // Reset mid-frame
    latch_frame(16'h00FF);
    for (int k = 0; k < 4; k++) one_pulse();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_data", data, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_count", fcount, 16'h0000);
    rst = 1'b0;
    exp_count = 16'h0000;
    repeat (2) @(negedge clk);
    model_frame(16'h00FF, 16, "post_rst");

`ifdef CTRL_RESP_TURBO_EN
    // Turbo: bit 0 alternates every 4 completed frames
    do_reset();
    tmask = 16'h0001;
    for (int f = 1; f <= 12; f++) begin
      latch_frame(16'h0001);
      chk($sformatf("turbo_f%0d", f), data, (((f - 1) / 4) % 2 == 1) ? 1'b1 : 1'b0);
      for (int k = 0; k < NB; k++) one_pulse();
      exp_count = exp_count + 16'd1;
      $display("turbo frame %0d bit0=%0b", f, data);
    end
    chk("turbo_count", fcount, 16'h000C);
    tmask = 16'h0000;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
